// File: rtl/layer_mixer.sv
// Composites NUM_LAYERS color layers into one pixel (fixed priority or OR-blend), with frame-synchronous config and blink.
// Latency: 2 clk from inputs to color_o/valid_o/winner_o, one pixel per cycle.
// Backpressure: none; the stream never stalls.
module layer_mixer #(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 3,
    parameter int TRANSPARENT  = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_color_i,
    input  logic [NUM_LAYERS-1:0]            layer_en_i,
    input  logic [NUM_LAYERS-1:0]            blink_en_i,
    input  logic                             mode_i,
    input  logic [COLOR_W-1:0]               bg_color_i,
    input  logic                             pix_valid_i,
    input  logic                             frame_start_i,
    output logic [COLOR_W-1:0]               color_o,
    output logic                             valid_o,
    output logic [$clog2(NUM_LAYERS+1)-1:0]  winner_o,
    output logic                             blink_phase_o
);
    localparam int WIN_W = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [COLOR_W-1:0] TRANSP   = COLOR_W'(TRANSPARENT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [WIN_W-1:0]   WIN_BG   = WIN_W'(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] shadow_en;
    logic [NUM_LAYERS-1:0] shadow_blink;
    logic                  shadow_mode;
    logic [CNT_W-1:0]      frame_cnt;
    logic                  blink_phase;

    // Config and blink state change only at frame boundaries, so a frame is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_en    <= '1;
            shadow_blink <= '0;
            shadow_mode  <= 1'b0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b1;
        end else if (frame_start_i) begin
            shadow_en    <= layer_en_i;
            shadow_blink <= blink_en_i;
            shadow_mode  <= mode_i;
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_phase_o = blink_phase;

    logic [NUM_LAYERS-1:0] vis;

    always_comb begin
        vis = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            vis[k] = shadow_en[k]
                   & (layer_color_i[k*COLOR_W +: COLOR_W] != TRANSP)
                   & (~shadow_blink[k] | blink_phase);
        end
    end

    logic [NUM_LAYERS-1:0]         s1_vis;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_colors;
    logic [COLOR_W-1:0]            s1_bg;
    logic                          s1_valid;
    logic                          s1_mode;

    // Mode travels with the pixel so a frame_start in flight cannot change how it resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vis    <= '0;
            s1_colors <= '0;
            s1_bg     <= '0;
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
        end else begin
            s1_vis    <= vis;
            s1_colors <= layer_color_i;
            s1_bg     <= bg_color_i;
            s1_valid  <= pix_valid_i;
            s1_mode   <= shadow_mode;
        end
    end

    logic [COLOR_W-1:0] prio_color;
    logic [COLOR_W-1:0] or_color;
    logic [WIN_W-1:0]   win;
    logic [COLOR_W-1:0] color_nxt;
    logic [WIN_W-1:0]   winner_nxt;

    always_comb begin
        prio_color = '0;
        or_color   = '0;
        win        = WIN_BG;
        // Descending scan so the lowest visible index is the last one written.
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (s1_vis[k]) begin
                prio_color = s1_colors[k*COLOR_W +: COLOR_W];
                win        = WIN_W'(k);
                or_color   = or_color | s1_colors[k*COLOR_W +: COLOR_W];
            end
        end
        color_nxt  = '0;
        winner_nxt = WIN_BG;
        if (s1_valid) begin
            winner_nxt = win;
            if (s1_vis == '0) begin
                color_nxt = s1_bg;
            end else if (s1_mode) begin
                color_nxt = or_color;
            end else begin
                color_nxt = prio_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_o  <= '0;
            valid_o  <= 1'b0;
            winner_o <= '0;
        end else begin
            color_o  <= color_nxt;
            valid_o  <= s1_valid;
            winner_o <= winner_nxt;
        end
    end
endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer with a reference model feeding a 2-deep expected-output queue.
module tb_layer_mixer;
    localparam int NL = 4;
    localparam int CW = 3;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NL*CW-1:0] layer_color_i = '0;
    logic [NL-1:0]  layer_en_i = '1;
    logic [NL-1:0]  blink_en_i = '0;
    logic           mode_i = 1'b0;
    logic [CW-1:0]  bg_color_i = '0;
    logic           pix_valid_i = 1'b0;
    logic           frame_start_i = 1'b0;
    logic [CW-1:0]  color_o;
    logic           valid_o;
    logic [2:0]     winner_o;
    logic           blink_phase_o;

    layer_mixer #(.NUM_LAYERS(NL), .COLOR_W(CW), .TRANSPARENT(0), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .layer_color_i(layer_color_i), .layer_en_i(layer_en_i),
        .blink_en_i(blink_en_i), .mode_i(mode_i), .bg_color_i(bg_color_i),
        .pix_valid_i(pix_valid_i), .frame_start_i(frame_start_i), .color_o(color_o),
        .valid_o(valid_o), .winner_o(winner_o), .blink_phase_o(blink_phase_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] c;
        logic [2:0] w;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic [NL-1:0] m_en;
    logic [NL-1:0] m_blink;
    logic          m_mode;
    int            m_cnt;
    logic          m_phase;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '1; m_blink = '0; m_mode = 1'b0; m_cnt = 0; m_phase = 1'b1;
    endtask

    function automatic exp_t predict(input logic [NL*CW-1:0] col, input logic pv, input logic [CW-1:0] bg);
        exp_t e;
        logic [CW-1:0] c;
        logic found;
        e = '{v: pv, c: 3'b000, w: 3'd4};
        found = 1'b0;
        c = '0;
        if (pv) begin
            for (int k = 0; k < NL; k++) begin
                logic [CW-1:0] lc;
                lc = col[k*CW +: CW];
                if (m_en[k] && lc != 3'b000 && (!m_blink[k] || m_phase)) begin
                    if (!found) begin
                        e.w = 3'(k);
                        if (!m_mode) c = lc;
                    end
                    if (m_mode) c = c | lc;
                    found = 1'b1;
                end
            end
            e.c = found ? c : bg;
        end
        return e;
    endfunction

    task automatic step(input logic [NL*CW-1:0] col, input logic pv, input logic fs,
                        input logic [NL-1:0] en, input logic [NL-1:0] bl, input logic md,
                        input logic [CW-1:0] bg);
        exp_t e;
        layer_color_i = col; pix_valid_i = pv; frame_start_i = fs;
        layer_en_i = en; blink_en_i = bl; mode_i = md; bg_color_i = bg;
        q.push_back(predict(col, pv, bg));
        if (fs) begin
            m_en = en; m_blink = bl; m_mode = md;
            if (m_cnt == BF - 1) begin
                m_cnt = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk); #1;
        check("blink_phase", 8'(blink_phase_o), 8'(m_phase));
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("valid", 8'(valid_o), 8'(e.v));
            check("color", 8'(color_o), 8'(e.c));
            check("winner", 8'(winner_o), 8'(e.w));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid_i = 1'b0; frame_start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_color", 8'(color_o), 8'h0);
        check("rst_valid", 8'(valid_o), 8'h0);
        check("rst_winner", 8'(winner_o), 8'h0);
        check("rst_phase", 8'(blink_phase_o), 8'h1);
        rst = 1'b0;
        model_reset();
        q.delete();
        q.push_back('{v: 1'b0, c: 3'b000, w: 3'd4});
    endtask

    // Layer packing: {layer3, layer2, layer1, layer0}
    localparam logic [11:0] L_PRIO = {3'b111, 3'b010, 3'b100, 3'b000};
    localparam logic [11:0] L_NONE = 12'h000;
    localparam logic [11:0] L_12   = {3'b000, 3'b010, 3'b100, 3'b000};

    initial begin
        model_reset();
        do_reset();

        // Fixed priority, then every layer transparent so background shows.
        step(L_PRIO, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);
        step(L_NONE, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);

        // OR-blend: the frame_start pixel still resolves with priority.
        step(L_12, 1, 1, 4'b1111, 4'b0000, 1, 3'b001);
        step(L_12, 1, 0, 4'b1111, 4'b0000, 1, 3'b001);
        step(L_12, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);
        step(L_12, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);

        // Back to priority, then disable layer 1 at the next frame.
        step(L_12, 1, 1, 4'b1111, 4'b0000, 0, 3'b001);
        step(L_12, 1, 1, 4'b1101, 4'b0000, 0, 3'b001);
        step(L_12, 1, 0, 4'b1101, 4'b0000, 0, 3'b001);
        step(L_12, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);

        // Blink layer 1 across several frames; phase flips every BF frame_starts.
        for (int f = 0; f < 6; f++) begin
            step(L_12, 1, 1, 4'b1111, 4'b0010, 0, 3'b001);
            for (int p = 0; p < 3; p++) step(L_12, 1, 0, 4'b0000, 4'b0000, 1, 3'b001);
        end

        // Inactive video.
        step(L_12, 0, 0, 4'b1111, 4'b0010, 0, 3'b001);
        step(L_12, 0, 0, 4'b1111, 4'b0010, 0, 3'b001);
        step(L_PRIO, 1, 0, 4'b1111, 4'b0010, 0, 3'b101);

        // Reset mid-stream, then resume.
        step(L_PRIO, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);
        do_reset();
        step(L_PRIO, 1, 0, 4'b1111, 4'b0000, 0, 3'b001);
        step(L_NONE, 1, 0, 4'b1111, 4'b0000, 0, 3'b110);
        step(L_NONE, 0, 0, 4'b1111, 4'b0000, 0, 3'b110);
        step(L_NONE, 0, 0, 4'b1111, 4'b0000, 0, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Parametrised, pipelined video layer compositor between the per-layer pixel generators (grid, score, banner, overlays) and the VGA driver's color input.
- Takes NUM_LAYERS color channels and resolves one output color per pixel, using either fixed priority or OR-blend.
- Adds per-layer enable, per-layer frame-synchronous blinking and frame-aligned config shadowing; a fixed 2-input priority mux has none of these.

Parameters:
- NUM_LAYERS, 4, number of input layers; layer 0 has highest priority.
- COLOR_W, 3, bits per color (RGB 1-bit each).
- TRANSPARENT, 0, color value treated as "no pixel".
- BLINK_FRAMES, 30, number of frame_start pulses per blink half-period; must be >= 1.

Ports:
- clk, input, 1, pixel/system clock.
- rst, input, 1, synchronous reset, active-high.
- layer_color_i, input, NUM_LAYERS*COLOR_W, packed layer colors; layer k at bits [k*COLOR_W +: COLOR_W].
- layer_en_i, input, NUM_LAYERS, requested layer enables.
- blink_en_i, input, NUM_LAYERS, requested per-layer blink enables.
- mode_i, input, 1, requested mode: 0 = priority, 1 = OR-blend.
- bg_color_i, input, COLOR_W, background color used when no layer is visible.
- pix_valid_i, input, 1, active-video qualifier for this pixel.
- frame_start_i, input, 1, one-cycle pulse at start of frame.
- color_o, output, COLOR_W, composited color.
- valid_o, output, 1, pix_valid_i delayed by 2 cycles.
- winner_o, output, $clog2(NUM_LAYERS+1), index of the winning layer; NUM_LAYERS means background.
- blink_phase_o, output, 1, current blink phase: 1 = blinking layers shown.

Behaviour:
- Reset (synchronous): color_o=0, valid_o=0, winner_o=0, blink_phase_o=1, frame counter=0, shadow layer_en=all 1s, shadow blink_en=0, shadow mode=0, pipeline registers=0.
- Config shadowing: shadow layer_en, blink_en and mode load from the inputs only on cycles where frame_start_i=1. Between frame_start pulses the inputs are ignored.
- Blink counter: increments on each frame_start_i. When the counter is at BLINK_FRAMES-1 and frame_start_i=1, it wraps to 0 and blink_phase toggles.
- Timing of frame_start effects: shadow and phase updates take effect for pixels sampled on the cycle after the frame_start pulse. A pixel sampled in the same cycle as frame_start_i uses the old values.
- Stage 1 (registered): compute the visibility vector. vis[k] = shadow_en[k] & (layer_color[k] != TRANSPARENT) & (~shadow_blink[k] | blink_phase). Register it with the colors and pix_valid.
- Stage 2 (registered):
  - If pix_valid is 0: color_o=0, winner_o=NUM_LAYERS.
  - Priority mode: color_o = color of the lowest-index visible layer; winner_o = that index.
  - OR mode: color_o = bitwise OR of all visible layer colors; winner_o = lowest visible index.
  - No visible layer: color_o = bg_color_i (the value sampled in stage 1), winner_o = NUM_LAYERS.
- Latency: exactly 2 clk from inputs to color_o/valid_o/winner_o. Fully pipelined, one pixel per cycle, no stalls.
- Simultaneous events: frame_start_i together with pix_valid_i is legal; that pixel uses old config. A counter wrap and a shadow load in the same cycle both apply.
- rst mid-frame: pipeline flushes. valid_o is 0 in the cycle after rst and stays 0 until two cycles after pix_valid_i is sampled high again.

Test Plan:
- Reset check: NUM_LAYERS=4, assert rst 1 cycle -> color_o=0, valid_o=0, blink_phase_o=1. With no frame_start, layers 0-3 remain enabled.
- Priority: layers={0:000, 1:100, 2:010, 3:111}, bg=001, pix_valid=1 -> two cycles later color_o=100, winner_o=1. Then set all layers 000 -> color_o=001, winner_o=4.
- OR mode: set mode_i=1, pulse frame_start, layers={0:000, 1:100, 2:010, 3:000} -> color_o=110, winner_o=1. Change mode_i back to 0 without a frame_start -> OR behaviour persists.
- Enable shadow: with layer_en_i=1101, pulse frame_start, layer1=100, layer2=010 -> color_o=010, winner_o=2. Pixel in the frame_start cycle still gives 100.
- Blink: BLINK_FRAMES=2, blink_en_i=0010, layer1=100, layer2=010. Phase toggles on every 2nd frame_start; output alternates 100 (phase 1) / 010 (phase 0) every 2 frames.
- Valid/reset mid-stream: pix_valid=0 -> color_o=0, winner_o=4 after 2 cycles. Assert rst during streaming -> valid_o=0 the following cycle.
